// File: rtl/multicycle_control.sv
// Multi-cycle control FSM for the RV32I core: sequences the shared ALU, the unified
// memory port, IR and PC across several cycles, with a sticky fault on illegal opcodes
// or memory stalls. Memory handshake: mem_req holds until the cycle mem_ready=1 completes it.
module multicycle_control #(
  parameter int STALL_LIMIT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op_code,
  input  logic [2:0] func3,
  input  logic [6:0] func7,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_write,
  output logic       adr_src,
  output logic       ir_write,
  output logic       pc_write,
  output logic       reg_write,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] result_source,
  output logic [2:0] alu_control,
  output logic [2:0] imm_type,
  output logic       retire,
  output logic [1:0] fault,
  output logic [3:0] state_dbg
);

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADR   = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXEC_R    = 4'd6,
    S_ALU_WB    = 4'd7,
    S_EXEC_I    = 4'd8,
    S_JAL       = 4'd9,
    S_BEQ       = 4'd10,
    S_HALT      = 4'd11
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam int CW     = (STALL_LIMIT > 1) ? $clog2(STALL_LIMIT + 1) : 1;
  localparam int LIM_M1 = (STALL_LIMIT > 0) ? STALL_LIMIT - 1 : 0;

  state_t        state, state_nxt;
  logic          run;
  logic [CW-1:0] stall_cnt, stall_nxt;
  logic [1:0]    fault_q, fault_nxt;
  logic          mem_access;
  logic          timeout;
  logic [2:0]    alu_dec;
  logic          unused_func7;

  assign unused_func7 = ^{func7[6], func7[4:0]};

  // Hitting the limit only faults when the access is still waiting this cycle.
  assign timeout = (STALL_LIMIT > 0) && (stall_cnt == LIM_M1[CW-1:0]);

  always_comb begin
    alu_dec = 3'b000;
    case (func3)
      3'b000:  alu_dec = (op_code[5] & func7[5]) ? 3'b001 : 3'b000;
      3'b010:  alu_dec = 3'b101;
      3'b110:  alu_dec = 3'b011;
      3'b111:  alu_dec = 3'b010;
      default: alu_dec = 3'b000;
    endcase
  end

  always_comb begin
    state_nxt     = state;
    fault_nxt     = fault_q;
    stall_nxt     = '0;
    mem_access    = 1'b0;
    mem_write     = 1'b0;
    adr_src       = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 2'b00;
    alu_src_b     = 2'b00;
    result_source = 2'b00;
    alu_control   = 3'b000;
    imm_type      = 3'b000;
    retire        = 1'b0;
    if (run) begin
      unique case (state)
        S_FETCH: begin
          mem_access    = 1'b1;
          alu_src_b     = 2'b10;
          result_source = 2'b10;
          if (mem_ready) begin
            ir_write  = 1'b1;
            pc_write  = 1'b1;
            state_nxt = S_DECODE;
          end
        end
        S_DECODE: begin
          // Branch/jump target is computed here; JAL needs the J immediate.
          alu_src_a = 2'b01;
          alu_src_b = 2'b01;
          imm_type  = (op_code == OP_JAL) ? 3'b011 : 3'b010;
          case (op_code)
            OP_LOAD, OP_STORE: state_nxt = S_MEM_ADR;
            OP_R:              state_nxt = S_EXEC_R;
            OP_I:              state_nxt = S_EXEC_I;
            OP_JAL:            state_nxt = S_JAL;
            OP_BRANCH:         state_nxt = S_BEQ;
            default: begin
              state_nxt = S_HALT;
              fault_nxt = 2'b01;
            end
          endcase
        end
        S_MEM_ADR: begin
          alu_src_a = 2'b10;
          alu_src_b = 2'b01;
          imm_type  = (op_code == OP_STORE) ? 3'b001 : 3'b000;
          state_nxt = (op_code == OP_STORE) ? S_MEM_WRITE : S_MEM_READ;
        end
        S_MEM_READ: begin
          mem_access = 1'b1;
          adr_src    = 1'b1;
          if (mem_ready) state_nxt = S_MEM_WB;
        end
        S_MEM_WB: begin
          result_source = 2'b01;
          reg_write     = 1'b1;
          retire        = 1'b1;
          state_nxt     = S_FETCH;
        end
        S_MEM_WRITE: begin
          mem_access = 1'b1;
          mem_write  = 1'b1;
          adr_src    = 1'b1;
          if (mem_ready) begin
            retire    = 1'b1;
            state_nxt = S_FETCH;
          end
        end
        S_EXEC_R: begin
          alu_src_a   = 2'b10;
          alu_control = alu_dec;
          state_nxt   = S_ALU_WB;
        end
        S_EXEC_I: begin
          alu_src_a   = 2'b10;
          alu_src_b   = 2'b01;
          alu_control = alu_dec;
          state_nxt   = S_ALU_WB;
        end
        S_ALU_WB: begin
          reg_write = 1'b1;
          retire    = 1'b1;
          state_nxt = S_FETCH;
        end
        S_JAL: begin
          alu_src_a = 2'b01;
          alu_src_b = 2'b10;
          pc_write  = 1'b1;
          reg_write = 1'b1;
          retire    = 1'b1;
          state_nxt = S_FETCH;
        end
        S_BEQ: begin
          alu_src_a   = 2'b10;
          alu_control = 3'b001;
          pc_write    = zero;
          retire      = 1'b1;
          state_nxt   = S_FETCH;
        end
        default: ;
      endcase
      if (mem_access && !mem_ready) begin
        if (timeout) begin
          state_nxt = S_HALT;
          fault_nxt = 2'b10;
        end else if (STALL_LIMIT > 0) begin
          stall_nxt = stall_cnt + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_FETCH;
      run       <= 1'b0;
      stall_cnt <= '0;
      fault_q   <= 2'b00;
    end else begin
      run       <= 1'b1;
      state     <= state_nxt;
      stall_cnt <= stall_nxt;
      fault_q   <= fault_nxt;
    end
  end

  assign mem_req   = mem_access;
  assign fault     = fault_q;
  assign state_dbg = state;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: per-cycle expected control words are queued with the
// mem_ready stimulus for each instruction, then popped and compared as the FSM runs.
module tb_multicycle_control;

  localparam int W = 25;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] op_code;
  logic [2:0] func3;
  logic [6:0] func7;
  logic       zero;
  logic       mem_ready;
  logic       mem_req, mem_write, adr_src, ir_write, pc_write, reg_write, retire;
  logic [1:0] alu_src_a, alu_src_b, result_source, fault;
  logic [2:0] alu_control, imm_type;
  logic [3:0] state_dbg;

  logic [W-1:0] exp_q[$];
  logic         rdy_q[$];
  int           errors = 0;
  int           checks = 0;

  multicycle_control #(.STALL_LIMIT(4)) dut (
    .clk(clk), .rst_n(rst_n), .op_code(op_code), .func3(func3), .func7(func7),
    .zero(zero), .mem_ready(mem_ready), .mem_req(mem_req), .mem_write(mem_write),
    .adr_src(adr_src), .ir_write(ir_write), .pc_write(pc_write), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .result_source(result_source),
    .alu_control(alu_control), .imm_type(imm_type), .retire(retire), .fault(fault),
    .state_dbg(state_dbg)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got no summary, required completion");
    $fatal(1);
  end

  function automatic logic [W-1:0] obs_vec();
    return {state_dbg, mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
            alu_src_a, alu_src_b, result_source, alu_control, imm_type, retire, fault};
  endfunction

  function automatic logic [W-1:0] ev(input logic [3:0] st, input logic req, wr, asrc,
                                      irw, pcw, rgw, input logic [1:0] sa, sb, rs,
                                      input logic [2:0] alu, imm, input logic ret,
                                      input logic [1:0] flt);
    return {st, req, wr, asrc, irw, pcw, rgw, sa, sb, rs, alu, imm, ret, flt};
  endfunction

  // Expected control word per state, straight from the state table.
  function automatic logic [W-1:0] e_idle();
    return '0;
  endfunction
  function automatic logic [W-1:0] e_fetch(input logic r);
    return ev(4'd0, 1, 0, 0, r, r, 0, 2'b00, 2'b10, 2'b10, 3'b000, 3'b000, 0, 2'b00);
  endfunction
  function automatic logic [W-1:0] e_decode(input logic j);
    return ev(4'd1, 0, 0, 0, 0, 0, 0, 2'b01, 2'b01, 2'b00, 3'b000,
              j ? 3'b011 : 3'b010, 0, 2'b00);
  endfunction
  function automatic logic [W-1:0] e_madr(input logic s);
    return ev(4'd2, 0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b00, 3'b000,
              s ? 3'b001 : 3'b000, 0, 2'b00);
  endfunction
  function automatic logic [W-1:0] e_mread();
    return ev(4'd3, 1, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 0, 2'b00);
  endfunction
  function automatic logic [W-1:0] e_mwb();
    return ev(4'd4, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b01, 3'b000, 3'b000, 1, 2'b00);
  endfunction
  function automatic logic [W-1:0] e_mwrite(input logic r);
    return ev(4'd5, 1, 1, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, r, 2'b00);
  endfunction
  function automatic logic [W-1:0] e_execr(input logic [2:0] a);
    return ev(4'd6, 0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b00, a, 3'b000, 0, 2'b00);
  endfunction
  function automatic logic [W-1:0] e_execi(input logic [2:0] a);
    return ev(4'd8, 0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b00, a, 3'b000, 0, 2'b00);
  endfunction
  function automatic logic [W-1:0] e_alu_wb();
    return ev(4'd7, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 1, 2'b00);
  endfunction
  function automatic logic [W-1:0] e_jal();
    return ev(4'd9, 0, 0, 0, 0, 1, 1, 2'b01, 2'b10, 2'b00, 3'b000, 3'b000, 1, 2'b00);
  endfunction
  function automatic logic [W-1:0] e_beq(input logic z);
    return ev(4'd10, 0, 0, 0, 0, z, 0, 2'b10, 2'b00, 2'b00, 3'b001, 3'b000, 1, 2'b00);
  endfunction
  function automatic logic [W-1:0] e_halt(input logic [1:0] f);
    return ev(4'd11, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 0, f);
  endfunction

  // Driver: queue one cycle's expected word with the mem_ready value for that cycle.
  task automatic push(input logic [W-1:0] e, input logic r);
    exp_q.push_back(e);
    rdy_q.push_back(r);
  endtask

  function automatic logic dc();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic test_reset();
    logic [W-1:0] ev_x, ob;
    int n;
    rst_n = 1'b1; mem_ready = 1'b1; zero = 1'b0;
    op_code = 7'b0010011; func3 = 3'b000; func7 = 7'b0100000;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (obs_vec() !== e_idle()) begin
      errors++;
      $display("FAIL reset_hold: got %h required %h", obs_vec(), e_idle());
    end
    rst_n = 1'b1;
    push(e_idle(), 1'b1); push(e_fetch(1), 1'b1); push(e_decode(0), dc());
    push(e_execi(3'b000), dc()); push(e_alu_wb(), dc());
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      mem_ready = rdy_q.pop_front();
      #1;
      ev_x = exp_q.pop_front(); ob = obs_vec(); checks++;
      if (ob !== ev_x) begin
        errors++;
        $display("FAIL reset_release cyc%0d: got %h required %h", i, ob, ev_x);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_lw();
    logic [W-1:0] ev_x, ob;
    int n;
    op_code = 7'b0000011; func3 = 3'b010; func7 = 7'($urandom_range(0, 127));
    push(e_fetch(1), 1'b1); push(e_decode(0), dc()); push(e_madr(0), dc());
    repeat (3) push(e_mread(), 1'b0);
    push(e_mread(), 1'b1); push(e_mwb(), dc());
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      mem_ready = rdy_q.pop_front();
      #1;
      ev_x = exp_q.pop_front(); ob = obs_vec(); checks++;
      if (ob !== ev_x) begin
        errors++;
        $display("FAIL lw cyc%0d: got %h required %h", i, ob, ev_x);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_sw();
    logic [W-1:0] ev_x, ob;
    int n;
    op_code = 7'b0100011; func3 = 3'b010; func7 = 7'($urandom_range(0, 127));
    push(e_fetch(0), 1'b0); push(e_fetch(1), 1'b1); push(e_decode(0), dc());
    push(e_madr(1), dc()); push(e_mwrite(0), 1'b0); push(e_mwrite(0), 1'b0);
    push(e_mwrite(1), 1'b1);
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      mem_ready = rdy_q.pop_front();
      #1;
      ev_x = exp_q.pop_front(); ob = obs_vec(); checks++;
      if (ob !== ev_x) begin
        errors++;
        $display("FAIL sw cyc%0d: got %h required %h", i, ob, ev_x);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_alu();
    logic [W-1:0] ev_x, ob;
    logic [2:0]   a;
    logic         is_i;
    int n;
    for (int k = 0; k < 9; k++) begin
      case (k)
        0: begin is_i = 0; func3 = 3'b000; func7 = 7'b0100000; a = 3'b001; end
        1: begin is_i = 0; func3 = 3'b000; func7 = 7'b0000000; a = 3'b000; end
        2: begin is_i = 0; func3 = 3'b111; func7 = 7'b0000000; a = 3'b010; end
        3: begin is_i = 0; func3 = 3'b110; func7 = 7'b0000000; a = 3'b011; end
        4: begin is_i = 0; func3 = 3'b010; func7 = 7'b0000000; a = 3'b101; end
        5: begin is_i = 0; func3 = 3'b001; func7 = 7'b0100000; a = 3'b000; end
        6: begin is_i = 1; func3 = 3'b000; func7 = 7'b0100000; a = 3'b000; end
        7: begin is_i = 1; func3 = 3'b010; func7 = 7'b0000000; a = 3'b101; end
        default: begin is_i = 1; func3 = 3'b111; func7 = 7'b0100000; a = 3'b010; end
      endcase
      op_code = is_i ? 7'b0010011 : 7'b0110011;
      push(e_fetch(1), 1'b1); push(e_decode(0), dc());
      push(is_i ? e_execi(a) : e_execr(a), dc()); push(e_alu_wb(), dc());
      n = exp_q.size();
      for (int i = 0; i < n; i++) begin
        mem_ready = rdy_q.pop_front();
        #1;
        ev_x = exp_q.pop_front(); ob = obs_vec(); checks++;
        if (ob !== ev_x) begin
          errors++;
          $display("FAIL alu case%0d cyc%0d: got %h required %h", k, i, ob, ev_x);
        end
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_jal_beq();
    logic [W-1:0] ev_x, ob;
    int n;
    op_code = 7'b1101111; func3 = 3'($urandom_range(0, 7));
    push(e_fetch(1), 1'b1); push(e_decode(1), dc()); push(e_jal(), dc());
    for (int z = 0; z < 2; z++) begin
      push(e_fetch(1), 1'b1); push(e_decode(0), dc()); push(e_beq(z[0]), dc());
    end
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      if (i == 3) op_code = 7'b1100011;
      zero = (i >= 6);
      mem_ready = rdy_q.pop_front();
      #1;
      ev_x = exp_q.pop_front(); ob = obs_vec(); checks++;
      if (ob !== ev_x) begin
        errors++;
        $display("FAIL jal_beq cyc%0d: got %h required %h", i, ob, ev_x);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_stall_boundary();
    logic [W-1:0] ev_x, ob;
    int n;
    op_code = 7'b0010011; func3 = 3'b110; func7 = 7'b0000000;
    repeat (3) push(e_fetch(0), 1'b0);
    push(e_fetch(1), 1'b1); push(e_decode(0), dc());
    push(e_execi(3'b011), dc()); push(e_alu_wb(), dc());
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      mem_ready = rdy_q.pop_front();
      #1;
      ev_x = exp_q.pop_front(); ob = obs_vec(); checks++;
      if (ob !== ev_x) begin
        errors++;
        $display("FAIL stall_boundary cyc%0d: got %h required %h", i, ob, ev_x);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_timeout();
    logic [W-1:0] ev_x, ob;
    int n;
    repeat (4) push(e_fetch(0), 1'b0);
    repeat (3) push(e_halt(2'b10), dc());
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      mem_ready = rdy_q.pop_front();
      #1;
      ev_x = exp_q.pop_front(); ob = obs_vec(); checks++;
      if (ob !== ev_x) begin
        errors++;
        $display("FAIL timeout cyc%0d: got %h required %h", i, ob, ev_x);
      end
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (obs_vec() !== e_idle()) begin
      errors++;
      $display("FAIL timeout_async_reset: got %h required %h", obs_vec(), e_idle());
    end
    @(posedge clk); #1;
  endtask

  task automatic test_illegal();
    logic [W-1:0] ev_x, ob;
    int n;
    op_code = 7'b1111111; mem_ready = 1'b1;
    rst_n = 1'b1;
    push(e_idle(), 1'b1); push(e_fetch(1), 1'b1); push(e_decode(0), 1'b1);
    repeat (4) push(e_halt(2'b01), 1'b1);
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      mem_ready = rdy_q.pop_front();
      #1;
      ev_x = exp_q.pop_front(); ob = obs_vec(); checks++;
      if (ob !== ev_x) begin
        errors++;
        $display("FAIL illegal cyc%0d: got %h required %h", i, ob, ev_x);
      end
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (fault !== 2'b00 || state_dbg !== 4'd0) begin
      errors++;
      $display("FAIL halt_reset_clear: got fault=%b state=%0d required fault=00 state=0",
               fault, state_dbg);
    end
    @(posedge clk); #1;
    rst_n = 1'b1; op_code = 7'b1101111;
    push(e_idle(), 1'b1); push(e_fetch(1), 1'b1); push(e_decode(1), dc()); push(e_jal(), dc());
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      mem_ready = rdy_q.pop_front();
      #1;
      ev_x = exp_q.pop_front(); ob = obs_vec(); checks++;
      if (ob !== ev_x) begin
        errors++;
        $display("FAIL recover cyc%0d: got %h required %h", i, ob, ev_x);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_sw();
    test_alu();
    test_jal_beq();
    test_stall_boundary();
    test_timeout();
    test_illegal();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Multi-cycle control FSM for the RV32I core.
- Sequences one shared ALU, one unified instruction/data memory port, the instruction register and the PC over several cycles per instruction.
- Replaces the single-cycle combinational decoder and keeps its encodings for alu_control, imm_type and opcodes.
- Sits between the instruction register (op_code/func3/func7), the datapath muxes/enables and the memory port (req/ready handshake).

Parameters:
STALL_LIMIT, 16, max consecutive cycles a memory state waits for mem_ready before faulting; 0 disables the timeout.

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
op_code  input  7  opcode from instruction register
func3  input  3  instr[14:12]
func7  input  7  instr[31:25]
zero  input  1  ALU zero flag
mem_ready  input  1  memory completes current access this cycle
mem_req  output  1  memory access request
mem_write  output  1  write strobe (valid with mem_req)
adr_src  output  1  address select: 0=PC, 1=ALU-out register
ir_write  output  1  load instruction register and old_pc
pc_write  output  1  load PC from result bus
reg_write  output  1  register file write
alu_src_a  output  2  00=PC, 01=old_pc, 10=rs1 register
alu_src_b  output  2  00=rs2 register, 01=immediate, 10=constant 4
result_source  output  2  00=ALU-out register, 01=memory data register, 10=ALU result (direct)
alu_control  output  3  000 add, 001 sub, 010 and, 011 or, 101 slt
imm_type  output  3  000 I, 001 S, 010 B, 011 J
retire  output  1  one-cycle pulse when an instruction completes
fault  output  2  00 none, 01 illegal opcode, 10 memory timeout; sticky
state_dbg  output  4  current state encoding

Behaviour:
- Reset: rst_n low asynchronously sets state=FETCH, run=0, stall counter=0, fault=00. All outputs are 0 while rst_n=0 and while run=0. run sets on the first clk edge after release, so mem_req first rises one cycle after rst_n deasserts.
- States and encodings: FETCH 0, DECODE 1, MEM_ADR 2, MEM_READ 3, MEM_WB 4, MEM_WRITE 5, EXEC_R 6, ALU_WB 7, EXEC_I 8, JAL 9, BEQ 10, HALT 11.
- FETCH:
  - mem_req=1, adr_src=0, alu_src_a=00, alu_src_b=10, alu_control=000, result_source=10.
  - When mem_ready=1, ir_write=1 and pc_write=1 in that same cycle (Mealy), then go to DECODE. Otherwise stay in FETCH.
- DECODE: alu_src_a=01, alu_src_b=01, imm_type=010, alu_control=000 (branch target precomputed). Next state by op_code:
  - 0000011 or 0100011 -> MEM_ADR
  - 0110011 -> EXEC_R
  - 0010011 -> EXEC_I
  - 1101111 -> JAL
  - 1100011 -> BEQ
  - any other -> HALT with fault=01
- MEM_ADR: alu_src_a=10, alu_src_b=01, add. imm_type=000 for loads, 001 for stores. Next is MEM_READ for load, MEM_WRITE for store.
- MEM_READ: mem_req=1, adr_src=1. Wait for mem_ready, then MEM_WB.
- MEM_WB: result_source=01, reg_write=1, retire=1, then FETCH.
- MEM_WRITE: mem_req=1, mem_write=1, adr_src=1. On mem_ready: retire=1, then FETCH.
- EXEC_R: alu_src_a=10, alu_src_b=00, ALU decode, then ALU_WB.
- EXEC_I: alu_src_a=10, alu_src_b=01, imm_type=000, ALU decode, then ALU_WB.
- ALU_WB: result_source=00, reg_write=1, retire=1, then FETCH.
- JAL:
  - alu_src_a=01, alu_src_b=10, result_source=00 (the target computed in DECODE with imm_type=011 is required).
  - Because of that, DECODE uses imm_type=011 when op_code=1101111.
  - pc_write=1, reg_write=1 of old_pc+4, retire=1, then FETCH.
- BEQ: alu_src_a=10, alu_src_b=00, alu_control=001, result_source=00, pc_write=zero, retire=1, then FETCH.
- ALU decode:
  - func3 000: sub if op_code[5]&func7[5], else add.
  - func3 010 -> 101; func3 110 -> 011; func3 111 -> 010; other func3 -> 000.
- Memory timeout:
  - In FETCH/MEM_READ/MEM_WRITE the stall counter increments each cycle with mem_req=1 and mem_ready=0, and clears on leaving the state.
  - If STALL_LIMIT>0 and the count reaches STALL_LIMIT, go to HALT with fault=10.
  - mem_ready arriving in the same cycle the limit is hit wins: the access completes and there is no fault.
- HALT: all strobes 0. Stays in HALT until reset.
- Unused outputs in any state are 0. retire never asserts outside the completion cycles listed above.

Test Plan:
- Reset release with mem_ready=1 -> mem_req=0 in the first cycle after release, 1 in the second. ir_write and pc_write pulse together, then state_dbg=1.
- lw (0000011) with mem_ready delayed 3 cycles in MEM_READ -> states 0,1,2,3,3,3,3,4,0. reg_write=1 and result_source=01 only in state 4. retire pulses once.
- sub (0110011, func3=000, func7=0100000) -> EXEC_R alu_control=001, ALU_WB reg_write=1. Total 4 cycles with zero-wait memory.
- beq with zero=0 then zero=1 -> pc_write=0, then pc_write=1 in BEQ. alu_control=001 in both cases.
- op_code 1111111 -> HALT, fault=01, no further mem_req. rst_n pulse mid-HALT clears fault to 00.
- STALL_LIMIT=4, mem_ready held 0 in FETCH -> fault=10 after 4 stall cycles. A run with mem_ready=1 exactly on cycle 4 completes with no fault.
